// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared definitions for the Morse digit transmitter.
//   - morseStateT  : FSM state type (IDLE / MARK / SPACE / GAP)
//   - digit_to_code: 4-bit digit -> 5-bit element pattern, MSB sent first,
//                    1 = dash, 0 = dot; digits above 9 map to all dots
//   - decoder protocol limits, in decoder strobes, and timingParamsOk()
//     which checks a set of key-side unit lengths against those limits.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        GAP
    } morseStateT;

    // What the receiving decoder accepts, counted in its own strobes.
    localparam int DEC_DOT_MAX_STROBES      = 3;
    localparam int DEC_DASH_MIN_STROBES     = 4;
    localparam int DEC_ELEM_GAP_MAX_STROBES = 6;
    localparam int DEC_CODE_GAP_MIN_STROBES = 7;

    // Standard Morse digits: 1..5 start with that many dots, 6..9 start with
    // (digit-5) dashes, and 0 is five dashes.
    function automatic logic [4:0] digit_to_code(input logic [3:0] digit);
        logic [4:0] code;
        case (digit)
            4'd0:    code = 5'b11111;
            4'd1:    code = 5'b01111;
            4'd2:    code = 5'b00111;
            4'd3:    code = 5'b00011;
            4'd4:    code = 5'b00001;
            4'd5:    code = 5'b00000;
            4'd6:    code = 5'b10000;
            4'd7:    code = 5'b11000;
            4'd8:    code = 5'b11100;
            4'd9:    code = 5'b11110;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

    // The key and the decoder strobe are not phase-locked, so an interval of
    // N units can be seen as N or N+1 strobes; every bound gives up one strobe.
    function automatic bit timingParamsOk(input int dotUnits,
                                          input int dashUnits,
                                          input int elemGap,
                                          input int codeGap);
        return (dotUnits >= 1) &&
               (dotUnits + 1 <= DEC_DOT_MAX_STROBES) &&
               (dashUnits - 1 >= DEC_DASH_MIN_STROBES) &&
               (elemGap >= 1) &&
               (elemGap + 1 <= DEC_ELEM_GAP_MAX_STROBES) &&
               (codeGap - 1 >= DEC_CODE_GAP_MIN_STROBES);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer
//   Prescaler plus unit counter that measures one interval of 'load' units,
//   each unit STROB_DIV clocks long.
//   Ports:
//     clock        in   clock
//     reset        in   asynchronous active-high reset
//     restart      in   start a new interval at the next edge; both counters clear
//     load         in   interval length in units, captured when restart is high
//     expire       out  registered pulse, high in the last clock of the interval
//     expireAhead  out  the value expire takes after the next edge
//   After expiring without a restart the timer stops and holds; it never wraps.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int STROB_DIV = 12_500_000,
    parameter int UNIT_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              restart,
    input  logic [UNIT_W-1:0] load,
    output logic              expire,
    output logic              expireAhead
);

    localparam int PRE_W = (STROB_DIV > 1) ? $clog2(STROB_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STROB_DIV - 1);

    logic [PRE_W-1:0]  preCount;
    logic [PRE_W-1:0]  preNext;
    logic [UNIT_W-1:0] unitCount;
    logic [UNIT_W-1:0] unitNext;
    logic [UNIT_W-1:0] target;
    logic [UNIT_W-1:0] targetNext;
    logic              running;
    logic              runningNext;

    // Next-state of the counters. The expire flag is derived from these next
    // values so it can be registered and still line up with the final clock
    // of the interval, including a one-clock interval right after restart.
    always_comb begin
        preNext     = preCount;
        unitNext    = unitCount;
        targetNext  = target;
        runningNext = running;
        if (restart) begin
            preNext     = '0;
            unitNext    = '0;
            targetNext  = load;
            runningNext = 1'b1;
        end else if (running) begin
            if (expire) begin
                runningNext = 1'b0;
            end else if (preCount == PRE_LAST) begin
                preNext  = '0;
                unitNext = unitCount + UNIT_W'(1);
            end else begin
                preNext = preCount + PRE_W'(1);
            end
        end
        expireAhead = runningNext &&
                      (preNext == PRE_LAST) &&
                      (unitNext == targetNext - UNIT_W'(1));
    end

    // Counter and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            preCount  <= '0;
            unitCount <= '0;
            target    <= '0;
            running   <= 1'b0;
            expire    <= 1'b0;
        end else begin
            preCount  <= preNext;
            unitCount <= unitNext;
            target    <= targetNext;
            running   <= runningNext;
            expire    <= expireAhead;
        end
    end

endmodule

// File: rtl/morse_digit_tx.sv
// morse_digit_tx
//   Keys the 5-element Morse code of a decimal digit onto M, with element and
//   gap lengths chosen so the matching digit decoder classifies them cleanly.
//   Ports:
//     C      in   clock
//     R      in   asynchronous active-high reset
//     Digit  in   digit to send, sampled when Start is accepted
//     Start  in   single-cycle request strobe
//     M      out  key output, 1 = mark (key down)
//     Busy   out  high from the cycle after acceptance to the end of the code gap
//     Done   out  one-cycle pulse in the last cycle of the code gap
//     Err    out  one-cycle pulse after a Start with Digit > 9
//   Build option: define MORSE_TX_QUEUE_EN for a one-entry pending buffer that
//   holds a Start arriving while busy and sends it straight after the code gap.
module morse_digit_tx
    import morse_pkg::*;
#(
    parameter int STROB_DIV  = 12_500_000,
    parameter int DOT_UNITS  = 1,
    parameter int DASH_UNITS = 5,
    parameter int ELEM_GAP   = 2,
    parameter int CODE_GAP   = 8
) (
    input  logic       C,
    input  logic       R,
    input  logic [3:0] Digit,
    input  logic       Start,
    output logic       M,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    localparam int MAX_A     = (DASH_UNITS > CODE_GAP) ? DASH_UNITS : CODE_GAP;
    localparam int MAX_B     = (DOT_UNITS > ELEM_GAP) ? DOT_UNITS : ELEM_GAP;
    localparam int MAX_UNITS = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int UNIT_W    = $clog2(MAX_UNITS + 1);

    localparam logic [UNIT_W-1:0] DOT_L  = UNIT_W'(DOT_UNITS);
    localparam logic [UNIT_W-1:0] DASH_L = UNIT_W'(DASH_UNITS);
    localparam logic [UNIT_W-1:0] ELEM_L = UNIT_W'(ELEM_GAP);
    localparam logic [UNIT_W-1:0] CODE_L = UNIT_W'(CODE_GAP);

    localparam bit TIMING_OK = timingParamsOk(DOT_UNITS, DASH_UNITS, ELEM_GAP, CODE_GAP);

    morseStateT        state;
    logic [4:0]        pattern;
    logic [2:0]        index;
    logic [4:0]        startCode;
    logic              validStart;
    logic              badStart;
    logic              restart;
    logic [UNIT_W-1:0] load;
    logic              expire;
    logic              expireAhead;
    logic              gapNext;
`ifdef MORSE_TX_QUEUE_EN
    logic              pending;
    logic [4:0]        pendCode;
    logic              chain;
    logic [4:0]        chainCode;
`endif

    function automatic logic [UNIT_W-1:0] markUnits(input logic isDash);
        return isDash ? DASH_L : DOT_L;
    endfunction

    assign startCode  = digit_to_code(Digit);
    assign validStart = Start && (Digit <= 4'd9);
    assign badStart   = Start && (Digit > 4'd9);

    morse_unit_timer #(
        .STROB_DIV (STROB_DIV),
        .UNIT_W    (UNIT_W)
    ) unitTimer (
        .clock       (C),
        .reset       (R),
        .restart     (restart),
        .load        (load),
        .expire      (expire),
        .expireAhead (expireAhead)
    );

    // Every state entry restarts the timer with the length of the interval
    // being entered, so no phase error builds up between elements. gapNext
    // marks that the FSM will be in GAP after this edge; combined with
    // expireAhead it lets Done be registered yet land on the final GAP clock.
    // The pattern is shifted on leaving MARK, so in SPACE bit 4 is already the
    // next element to send.
    always_comb begin
        restart = 1'b0;
        load    = '0;
        gapNext = 1'b0;
`ifdef MORSE_TX_QUEUE_EN
        chain     = 1'b0;
        chainCode = pendCode;
`endif
        case (state)
            IDLE: begin
                if (validStart) begin
                    restart = 1'b1;
                    load    = markUnits(startCode[4]);
                end
            end
            MARK: begin
                if (expire) begin
                    restart = 1'b1;
                    load    = (index == 3'd4) ? CODE_L : ELEM_L;
                    gapNext = (index == 3'd4);
                end
            end
            SPACE: begin
                if (expire) begin
                    restart = 1'b1;
                    load    = markUnits(pattern[4]);
                end
            end
            GAP: begin
                gapNext = !expire;
`ifdef MORSE_TX_QUEUE_EN
                // A Start in the final GAP clock is newer than the buffered
                // entry, so it wins and goes out directly.
                if (expire && (validStart || pending)) begin
                    chain     = 1'b1;
                    chainCode = validStart ? startCode : pendCode;
                    restart   = 1'b1;
                    load      = markUnits(chainCode[4]);
                end
`endif
            end
            default: begin
                restart = 1'b0;
            end
        endcase
    end

    // Main FSM. All outputs are registers, so reset pulls M low immediately.
    // Without the queue a Start while busy, valid or not, is dropped silently.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state   <= IDLE;
            pattern <= '0;
            index   <= '0;
            M       <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
`ifdef MORSE_TX_QUEUE_EN
            pending  <= 1'b0;
            pendCode <= '0;
`endif
        end else begin
            Done <= gapNext && expireAhead;
            Err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (validStart) begin
                        pattern <= startCode;
                        index   <= '0;
                        M       <= 1'b1;
                        Busy    <= 1'b1;
                        state   <= MARK;
                    end else if (badStart) begin
                        Err <= 1'b1;
                    end
                end
                MARK: begin
                    if (expire) begin
                        M       <= 1'b0;
                        pattern <= {pattern[3:0], 1'b0};
                        state   <= (index == 3'd4) ? GAP : SPACE;
                    end
                end
                SPACE: begin
                    if (expire) begin
                        index <= index + 3'd1;
                        M     <= 1'b1;
                        state <= MARK;
                    end
                end
                GAP: begin
                    if (expire) begin
`ifdef MORSE_TX_QUEUE_EN
                        if (chain) begin
                            pattern <= chainCode;
                            index   <= '0;
                            M       <= 1'b1;
                            state   <= MARK;
                        end else begin
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end
`else
                        Busy  <= 1'b0;
                        state <= IDLE;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef MORSE_TX_QUEUE_EN
            // While busy, a valid Start overwrites the buffer and an invalid
            // one only raises Err; chaining consumes whatever was pending.
            if (state != IDLE) begin
                if (chain) begin
                    pending <= 1'b0;
                end else if (validStart) begin
                    pending  <= 1'b1;
                    pendCode <= startCode;
                end
                if (badStart) begin
                    Err <= 1'b1;
                end
            end
`endif
        end
    end

    // Element and gap lengths outside the decoder's window would make it
    // misread the code; flag such a parameter set in simulation.
    always_ff @(posedge C) begin
        if (!R) begin
            assert (TIMING_OK);
        end
    end

endmodule
